// File: rtl/ps2_key_ctrl_if.sv
// Keyboard event bus between the PS/2 receiver/CPU side and the key controller.
// Latency: wiring only, no registers.
// Backpressure: rx_wait tells the receiver to hold off; rd_en pops the head event.
interface ps2_key_ctrl_if #(
   parameter int ADDR_W = 3
);
   logic [7:0]      rx_byte;
   logic            rx_valid;
   logic            rx_wait;
   logic            rd_en;
   logic            evt_valid;
   logic [9:0]      evt_data;
   logic [ADDR_W:0] evt_count;
   logic            overflow;
   logic            clear_ovf;
   logic            shift_held;
   logic            ctrl_held;

   // Receiver/CPU side: drives bytes, pops and overflow clears
   modport master (
      output rx_byte, rx_valid, rd_en, clear_ovf,
      input  rx_wait, evt_valid, evt_data, evt_count, overflow, shift_held, ctrl_held
   );

   // Key controller side
   modport slave (
      input  rx_byte, rx_valid, rd_en, clear_ovf,
      output rx_wait, evt_valid, evt_data, evt_count, overflow, shift_held, ctrl_held
   );
endinterface

// File: rtl/ps2_key_ctrl.sv
// Folds PS/2 scan-code prefixes into key events, queues them show-ahead, tracks Shift/Ctrl.
// Latency: event visible and modifiers updated one cycle after the final byte's strobe.
// Backpressure: rx_wait drops the cycle after the FIFO fills; events arriving while full are dropped.
module ps2_key_ctrl #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic          clk_i,
   input  logic          rst_i,
   ps2_key_ctrl_if.slave bus
);

   localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_EXT,
      S_BRK,
      S_EXT_BRK,
      S_PAUSE
   } state_t;

   state_t          state_q, state_d;
   logic [2:0]      skip_q, skip_d;
   logic            push;
   logic [9:0]      push_dat;
   logic            noise;

   logic [9:0]      mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [ADDR_W:0] count_q;
   logic            ovf_q;
   logic            rx_wait_q;
   logic            shift_l_q, shift_r_q, ctrl_l_q, ctrl_r_q;

   logic            pop, full, accept, drop;

   // Acks, BAT result, echo, resend and error bytes carry no key information
   assign noise = (bus.rx_byte == 8'h00) || (bus.rx_byte == 8'hAA) ||
                  (bus.rx_byte == 8'hEE) || (bus.rx_byte == 8'hFA) ||
                  (bus.rx_byte == 8'hFE) || (bus.rx_byte == 8'hFF);

   // Prefix decoder: next state and the event produced by this byte, if any
   always_comb begin
      state_d  = state_q;
      skip_d   = skip_q;
      push     = 1'b0;
      push_dat = '0;
      if (bus.rx_valid) begin
         case (state_q)
            S_IDLE: begin
               if (bus.rx_byte == 8'hE0) begin
                  state_d = S_EXT;
               end else if (bus.rx_byte == 8'hF0) begin
                  state_d = S_BRK;
               end else if (bus.rx_byte == 8'hE1) begin
                  state_d = S_PAUSE;
                  skip_d  = 3'd7;
               end else if (!noise) begin
                  push     = 1'b1;
                  push_dat = {2'b00, bus.rx_byte};
               end
            end
            S_EXT: begin
               if (bus.rx_byte == 8'hF0) begin
                  state_d = S_EXT_BRK;
               end else if (bus.rx_byte != 8'hE0) begin
                  push     = 1'b1;
                  push_dat = {2'b10, bus.rx_byte};
                  state_d  = S_IDLE;
               end
            end
            S_BRK: begin
               if (bus.rx_byte != 8'hE0 && bus.rx_byte != 8'hF0) begin
                  push     = 1'b1;
                  push_dat = {2'b01, bus.rx_byte};
                  state_d  = S_IDLE;
               end
            end
            S_EXT_BRK: begin
               if (bus.rx_byte != 8'hE0 && bus.rx_byte != 8'hF0) begin
                  push     = 1'b1;
                  push_dat = {2'b11, bus.rx_byte};
                  state_d  = S_IDLE;
               end
            end
            S_PAUSE: begin
               // The whole 8-byte Pause sequence collapses into one extended E1 event
               if (skip_q == 3'd1) begin
                  push     = 1'b1;
                  push_dat = {2'b10, 8'hE1};
                  skip_d   = 3'd0;
                  state_d  = S_IDLE;
               end else begin
                  skip_d = skip_q - 3'd1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // A push into a full FIFO still fits if the head leaves in the same cycle
   always_comb begin
      full   = (count_q == FULL);
      pop    = bus.rd_en && (count_q != '0);
      accept = push && (!full || pop);
      drop   = push && !accept;
   end

   // Decoder state, FIFO pointers/occupancy, overflow flag and receiver inhibit
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         skip_q    <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         rx_wait_q <= 1'b1;
      end else begin
         state_q <= state_d;
         skip_q  <= skip_d;
         if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
         if (accept && !pop)      count_q <= count_q + 1'b1;
         else if (!accept && pop) count_q <= count_q - 1'b1;
         if (drop)               ovf_q <= 1'b1;
         else if (bus.clear_ovf) ovf_q <= 1'b0;
         rx_wait_q <= !full;
      end
   end

   // Event storage; contents need no reset since evt_data is masked while empty
   always_ff @(posedge clk_i) begin
      if (!rst_i && accept) mem_q[wr_ptr_q] <= push_dat;
   end

   // Modifier tracking follows every decoded event, even ones the FIFO drops
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shift_l_q <= 1'b0;
         shift_r_q <= 1'b0;
         ctrl_l_q  <= 1'b0;
         ctrl_r_q  <= 1'b0;
      end else if (push) begin
         if (!push_dat[9] && push_dat[7:0] == 8'h12) shift_l_q <= !push_dat[8];
         if (!push_dat[9] && push_dat[7:0] == 8'h59) shift_r_q <= !push_dat[8];
         if (!push_dat[9] && push_dat[7:0] == 8'h14) ctrl_l_q  <= !push_dat[8];
         if ( push_dat[9] && push_dat[7:0] == 8'h14) ctrl_r_q  <= !push_dat[8];
      end
   end

   assign bus.evt_valid  = (count_q != '0);
   assign bus.evt_data   = bus.evt_valid ? mem_q[rd_ptr_q] : '0;
   assign bus.evt_count  = count_q;
   assign bus.overflow   = ovf_q;
   assign bus.rx_wait    = rx_wait_q;
   assign bus.shift_held = shift_l_q | shift_r_q;
   assign bus.ctrl_held  = ctrl_l_q | ctrl_r_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Self-checking bench for ps2_key_ctrl: directed scan-code sequences plus random byte streams.
// Latency: expects events/modifiers one cycle after the strobe.
// Backpressure: exercises full FIFO, simultaneous push/pop and overflow clear.
module tb_ps2_key_ctrl;
   localparam int DEPTH  = 8;
   localparam int ADDR_W = 3;

   logic clk = 1'b0;
   logic rst;
   always #10 clk = ~clk;

   ps2_key_ctrl_if #(.ADDR_W(ADDR_W)) ifc ();

   ps2_key_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (ifc)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: FIFO contents as a queue, prefixes as flags
   logic [9:0] exp_q[$];
   bit         m_ext, m_brk;
   int         m_pause;
   bit         sh_l, sh_r, ct_l, ct_r, m_ovf, m_drop, have_new;
   logic [9:0] new_evt;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      m_ext = 0; m_brk = 0; m_pause = 0;
      sh_l = 0; sh_r = 0; ct_l = 0; ct_r = 0; m_ovf = 0;
   endtask

   task automatic model_event(input logic [9:0] e, input bit rd);
      if (!e[9] && e[7:0] == 8'h12) sh_l = !e[8];
      if (!e[9] && e[7:0] == 8'h59) sh_r = !e[8];
      if (!e[9] && e[7:0] == 8'h14) ct_l = !e[8];
      if ( e[9] && e[7:0] == 8'h14) ct_r = !e[8];
      if (exp_q.size() < DEPTH || (rd && exp_q.size() > 0)) begin
         have_new = 1;
         new_evt  = e;
      end else begin
         m_drop = 1;
      end
   endtask

   task automatic model_byte(input logic [7:0] b, input bit rd);
      if (m_pause > 0) begin
         m_pause--;
         if (m_pause == 0) model_event({2'b10, 8'hE1}, rd);
      end else if (b == 8'hF0) begin
         m_brk = 1;
      end else if (b == 8'hE0) begin
         if (!m_brk) m_ext = 1;
      end else if (!m_ext && !m_brk && b == 8'hE1) begin
         m_pause = 7;
      end else if (!m_ext && !m_brk && (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF})) begin
         // status byte, no event
      end else begin
         model_event({m_ext, m_brk, b}, rd);
         m_ext = 0;
         m_brk = 0;
      end
   endtask

   // One clock of stimulus; model updated as it is issued, outputs checked after the edge
   task automatic drive(input logic [7:0] b, input bit v, input bit rd, input bit clr);
      int cnt_pre;
      m_drop   = 0;
      have_new = 0;
      cnt_pre  = exp_q.size();
      ifc.rx_byte   = b;
      ifc.rx_valid  = v;
      ifc.rd_en     = rd;
      ifc.clear_ovf = clr;
      if (v) model_byte(b, rd);
      if (m_drop) m_ovf = 1;
      else if (clr) m_ovf = 0;
      @(posedge clk);
      #2;
      ifc.rx_valid  = 1'b0;
      ifc.rd_en     = 1'b0;
      ifc.clear_ovf = 1'b0;
      if (have_new) exp_q.push_back(new_evt);
      chk("evt_count", int'(ifc.evt_count), exp_q.size());
      chk("evt_valid", int'(ifc.evt_valid), int'(exp_q.size() > 0));
      chk("overflow", int'(ifc.overflow), int'(m_ovf));
      chk("shift_held", int'(ifc.shift_held), int'(sh_l | sh_r));
      chk("ctrl_held", int'(ifc.ctrl_held), int'(ct_l | ct_r));
      chk("rx_wait", int'(ifc.rx_wait), int'(cnt_pre != DEPTH));
      if (exp_q.size() > 0) chk("head_data", int'(ifc.evt_data), int'(exp_q[0]));
   endtask

   task automatic send(input logic [7:0] b);
      drive(b, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic pop_one();
      drive(8'h00, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic do_reset(input bit noisy);
      rst = 1'b1;
      ifc.rx_byte   = 8'h1C;
      ifc.rx_valid  = noisy;
      ifc.rd_en     = noisy;
      ifc.clear_ovf = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b0;
      ifc.rx_valid = 1'b0;
      ifc.rd_en    = 1'b0;
      model_clear();
      chk("rst_count", int'(ifc.evt_count), 0);
      chk("rst_valid", int'(ifc.evt_valid), 0);
      chk("rst_data", int'(ifc.evt_data), 0);
      chk("rst_ovf", int'(ifc.overflow), 0);
      chk("rst_shift", int'(ifc.shift_held), 0);
      chk("rst_ctrl", int'(ifc.ctrl_held), 0);
      chk("rst_rx_wait", int'(ifc.rx_wait), 1);
   endtask

   // Monitor: whenever a pop is presented, the head must match the scoreboard front
   always @(negedge clk) begin
      if (!rst && ifc.rd_en && exp_q.size() > 0) begin
         chk("pop_valid", int'(ifc.evt_valid), 1);
         chk("pop_data", int'(ifc.evt_data), int'(exp_q[0]));
         void'(exp_q.pop_front());
      end
   end

   logic [7:0] rb;
   initial begin
      model_clear();
      do_reset(1'b1);

      // make/break
      send(8'h1C); send(8'hF0); send(8'h1C);
      chk("mb_count", int'(ifc.evt_count), 2);
      pop_one(); pop_one();
      chk("mb_empty", int'(ifc.evt_valid), 0);

      // extended keys with status bytes in between
      send(8'hE0); send(8'h75); send(8'hFA);
      send(8'hE0); send(8'hF0); send(8'h75); send(8'hAA); send(8'h00);
      chk("ext_count", int'(ifc.evt_count), 2);
      chk("ext_head", int'(ifc.evt_data), 10'h275);
      pop_one(); pop_one();

      // pause sequence then a normal key
      send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
      send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
      chk("pause_count", int'(ifc.evt_count), 1);
      chk("pause_head", int'(ifc.evt_data), 10'h2E1);
      send(8'h1C);
      pop_one(); pop_one();

      // modifiers
      send(8'h12); send(8'h59); send(8'hF0); send(8'h12);
      chk("shift_one_side", int'(ifc.shift_held), 1);
      send(8'hF0); send(8'h59);
      chk("shift_released", int'(ifc.shift_held), 0);
      send(8'hE0); send(8'h14);
      chk("rctrl_down", int'(ifc.ctrl_held), 1);
      send(8'hE0); send(8'hF0); send(8'h14);
      chk("rctrl_up", int'(ifc.ctrl_held), 0);
      for (int i = 0; i < 10; i++) pop_one();

      // fill, overflow, push+pop at full, clear, drain below full
      for (int i = 0; i < 9; i++) send(8'h20 + 8'(i));
      chk("full_count", int'(ifc.evt_count), DEPTH);
      chk("full_ovf", int'(ifc.overflow), 1);
      chk("full_head", int'(ifc.evt_data), 10'h020);
      chk("full_rx_wait", int'(ifc.rx_wait), 0);
      drive(8'h3A, 1'b1, 1'b1, 1'b0);
      chk("full_pushpop_count", int'(ifc.evt_count), DEPTH);
      drive(8'h00, 1'b0, 1'b0, 1'b1);
      chk("ovf_cleared", int'(ifc.overflow), 0);
      pop_one(); pop_one();
      chk("rx_wait_back", int'(ifc.rx_wait), 1);
      for (int i = 0; i < DEPTH; i++) pop_one();

      // reset mid-sequence
      send(8'hE0);
      do_reset(1'b0);
      send(8'h75);
      chk("midrst_head", int'(ifc.evt_data), 10'h075);
      pop_one();
      pop_one();
      chk("empty_pop_count", int'(ifc.evt_count), 0);

      // random byte streams
      for (int i = 0; i < 600; i++) begin
         case ($urandom_range(0, 11))
            0:       rb = 8'hE0;
            1, 2:    rb = 8'hF0;
            3:       rb = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'h1C;
            4:       rb = 8'h12;
            5:       rb = 8'h59;
            6:       rb = 8'h14;
            7:       rb = ($urandom_range(0, 1) == 0) ? 8'hFA : 8'hAA;
            default: rb = 8'($urandom_range(0, 255));
         endcase
         if ($urandom_range(0, 149) == 0) do_reset($urandom_range(0, 1) == 1);
         else drive(rb, $urandom_range(0, 5) != 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 15) == 0);
      end
      for (int i = 0; i < DEPTH + 2; i++) pop_one();
      chk("final_empty", int'(ifc.evt_valid), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ps2_key_ctrl.md
Name: ps2_key_ctrl

Overview:
- Sequencer and buffer behind the PS/2 byte receiver (ps2_in).
- Consumes raw scan-code bytes (one-cycle strobe per byte) and folds 0xE0 extended / 0xF0 break / 0xE1 pause prefixes into single key events.
- Queues events in a show-ahead FIFO for the CPU I/O port, tracks Shift/Ctrl held state, and drives the receiver's wait_for_data to inhibit the keyboard when the FIFO is full.

Parameters:
- DEPTH, 8: FIFO entries; power of two, >= 2.
- ADDR_W, 3: log2(DEPTH).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous reset, active-high.
- rx_byte  in  8  byte from receiver (byte_data).
- rx_valid  in  1  one-cycle strobe, rx_byte valid (full_byte_received).
- rx_wait  out  1  to receiver wait_for_data; 1 = accept keyboard data.
- rd_en  in  1  CPU pop of head event.
- evt_valid  out  1  FIFO non-empty.
- evt_data  out  10  head event {ext, brk, code[7:0]}.
- evt_count  out  ADDR_W+1  FIFO occupancy 0..DEPTH.
- overflow  out  1  sticky; event dropped while FIFO full.
- clear_ovf  in  1  clears overflow.
- shift_held  out  1  left or right Shift down.
- ctrl_held  out  1  Ctrl down (left or right).

Behaviour:
- Reset (rst=1 at clk edge):
  - FSM to IDLE, FIFO emptied, skip counter 0.
  - overflow, shift_held, ctrl_held, evt_count, evt_valid = 0; evt_data = 0; rx_wait = 1.
  - rx_valid and rd_en are ignored in any cycle with rst=1.
- Decoder FSM advances only on cycles with rx_valid=1. b = rx_byte.
  - IDLE:
    - b=E0 -> EXT.
    - b=F0 -> BRK.
    - b=E1 -> PAUSE, skip_cnt=7.
    - b in {00,AA,EE,FA,FE,FF} -> discard, stay IDLE.
    - else push {0,0,b}.
  - EXT:
    - b=F0 -> EXT_BRK.
    - b=E0 -> stay EXT.
    - else push {1,0,b}, -> IDLE.
  - BRK: b=E0 or F0 -> discard, stay BRK; else push {0,1,b}, -> IDLE.
  - EXT_BRK: b=E0 or F0 -> discard, stay EXT_BRK; else push {1,1,b}, -> IDLE.
  - PAUSE:
    - Decrement skip_cnt.
    - When the byte arrives with skip_cnt=1: push {1,0,E1}, -> IDLE.
    - All 7 trailing bytes are consumed and emit nothing else.
- Modifiers, updated on every decoded event whether or not the FIFO accepts it:
  - Non-ext code 12 (left) or 59 (right): make sets that side's internal bit, break clears it. shift_held = left OR right.
  - Code 14, ext (right) or non-ext (left): same rule. ctrl_held = left OR right.
  - Registered; they change the cycle after the rx_valid cycle.
- FIFO:
  - Show-ahead. evt_data = entry at the read pointer; evt_valid = (count != 0).
  - A pushed event is visible one cycle after its rx_valid cycle.
  - Pop occurs when rd_en=1 and count>0. rd_en with count=0 is ignored; pointers and count are unchanged.
  - A push is accepted when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle. Otherwise the event is dropped and overflow is set the next cycle.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
  - overflow clears on clear_ovf=1. If clear_ovf and a new drop occur in the same cycle, the set wins.
- rx_wait:
  - Registered. rx_wait = 0 on the cycle after count reaches DEPTH.
  - Returns to 1 on the cycle after count drops below DEPTH.
  - Bytes still arriving while rx_wait=0 are decoded normally; dropped events set overflow.
- Reset mid-sequence (e.g. after E0 or in PAUSE): state is abandoned, FSM returns to IDLE, and the next byte is decoded from IDLE.

Test Plan:
- Basic make/break: bytes 1C, then F0,1C -> two events 01C then 11C (binary {ext,brk} = 00, 01); evt_count=2; popping both -> evt_valid=0.
- Extended: E0,75 then E0,F0,75 -> events 275 then 375; ack/noise bytes FA, AA, 00 interleaved -> no events.
- Pause: E1,14,77,E1,F0,14,F0,77 -> exactly one event 2E1; next byte 1C -> 01C.
- Modifiers: 12 -> shift_held=1; 59 -> still 1; F0,12 -> still 1; F0,59 -> 0. E0,14 -> ctrl_held=1; E0,F0,14 -> 0.
- Full/overflow: 9 makes with DEPTH=8 and no pops -> count=8, rx_wait=0, 9th event dropped, overflow=1, head still the 1st event. Push and pop in the same cycle at count=8 -> accepted, count stays 8. clear_ovf -> overflow=0. Pop to 7 -> rx_wait=1.
- Reset mid-sequence: E0, then rst pulse, then 75 -> event 075, FIFO contains only it, overflow=0. rd_en on empty FIFO -> no change.
